piezo_dur_timer: RTL and testbench



---
 rtl/piezo_dur_timer_pkg.sv | 13 +
 rtl/piezo_dur_timer_if.sv | 25 ++
 rtl/piezo_dur_timer_tick_gen.sv | 29 ++
 rtl/piezo_dur_timer.sv | 169 ++++++++++++++++
 tb/tb_piezo_dur_timer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/piezo_dur_timer_pkg.sv
// Shared types and constants for the piezo note-duration timer.
package piezo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } dur_state_t;

    localparam int unsigned PIEZO_TICK_DIV_50MHZ = 500000;
    localparam int unsigned PIEZO_DUR_W_DEFAULT  = 8;

endpackage

// File: rtl/piezo_dur_timer_if.sv
// Start/busy/note_over handshake between the tune sequencer and the duration timer.
interface piezo_dur_timer_if
    import piezo_pkg::*;
#(
    parameter int unsigned DUR_W = PIEZO_DUR_W_DEFAULT
);
    logic             start;
    logic             abort;
    logic             pause;
    logic [DUR_W-1:0] note_dur;
    logic             busy;
    logic             note_on;
    logic             note_over;
    logic             ready;

    modport master (
        output start, abort, pause, note_dur,
        input  busy, note_on, note_over, ready
    );

    modport slave (
        input  start, abort, pause, note_dur,
        output busy, note_on, note_over, ready
    );
endinterface

// File: rtl/piezo_dur_timer_tick_gen.sv
// Duration-tick prescaler: one tick every TICK_DIV unheld clk cycles.
module piezo_tick_gen
    import piezo_pkg::*;
#(
    parameter int unsigned TICK_DIV = PIEZO_TICK_DIV_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int unsigned         CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST) && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/piezo_dur_timer.sv
// Note-duration timer: times a note plus a silent gap and reports completion.
// Optional one-entry pending-note buffer enabled by PIEZO_DUR_QUEUE_EN.
module piezo_dur_timer
    import piezo_pkg::*;
#(
    parameter int unsigned TICK_DIV  = PIEZO_TICK_DIV_50MHZ,
    parameter int unsigned DUR_W     = PIEZO_DUR_W_DEFAULT,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    piezo_dur_timer_if.slave bus
);
    localparam int unsigned      GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    dur_state_t       state, state_nxt;
    logic [DUR_W-1:0] dur_lat, dur_lat_nxt;
    logic [DUR_W-1:0] dur_cnt, dur_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             busy_q, over_q, over_nxt;
    logic             tick, launch, done, accept, ready_c;
    logic [DUR_W-1:0] launch_dur;
`ifdef PIEZO_DUR_QUEUE_EN
    logic             pend_valid, pend_valid_nxt, from_pend;
    logic [DUR_W-1:0] pend_dur, pend_dur_nxt;

    assign ready_c = (!pend_valid || (state == IDLE)) && !bus.abort;
`else
    assign ready_c = (state == IDLE) && !bus.abort;
`endif
    assign accept        = bus.start && ready_c;
    assign bus.ready     = ready_c;
    assign bus.busy      = busy_q;
    assign bus.note_over = over_q;
    assign bus.note_on   = (state == NOTE) && !bus.pause;

    piezo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch || bus.abort),
        .hold (bus.pause || (state == IDLE)),
        .tick (tick)
    );

    // Next-state, counter and completion logic; abort overrides everything last.
    always_comb begin
        state_nxt   = state;
        dur_lat_nxt = dur_lat;
        dur_cnt_nxt = dur_cnt;
        gap_cnt_nxt = gap_cnt;
        over_nxt    = 1'b0;
        launch      = 1'b0;
        launch_dur  = bus.note_dur;
        done        = 1'b0;
`ifdef PIEZO_DUR_QUEUE_EN
        from_pend      = 1'b0;
        pend_valid_nxt = pend_valid;
        pend_dur_nxt   = pend_dur;
`endif
        unique case (state)
            IDLE: begin
`ifdef PIEZO_DUR_QUEUE_EN
                if (pend_valid) begin
                    launch     = 1'b1;
                    launch_dur = pend_dur;
                    from_pend  = 1'b1;
                end else if (accept) begin
                    launch = 1'b1;
                end
`else
                if (accept) launch = 1'b1;
`endif
            end
            NOTE: begin
                if (tick) begin
                    if (dur_cnt == dur_lat - DUR_W'(1)) begin
                        dur_cnt_nxt = '0;
                        if (GAP_TICKS == 0) done = 1'b1;
                        else                state_nxt = GAP;
                    end else begin
                        dur_cnt_nxt = dur_cnt + DUR_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt_nxt = '0;
                        done        = 1'b1;
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (done) begin
            state_nxt = IDLE;
            over_nxt  = 1'b1;
`ifdef PIEZO_DUR_QUEUE_EN
            if (pend_valid) begin
                launch     = 1'b1;
                launch_dur = pend_dur;
                from_pend  = 1'b1;
            end
`endif
        end

        // A zero-length note goes straight to the gap, or completes at once without one.
        if (launch) begin
            dur_lat_nxt = launch_dur;
            dur_cnt_nxt = '0;
            gap_cnt_nxt = '0;
            if (launch_dur != '0)    state_nxt = NOTE;
            else if (GAP_TICKS != 0) state_nxt = GAP;
            else begin
                state_nxt = IDLE;
                over_nxt  = 1'b1;
            end
        end

`ifdef PIEZO_DUR_QUEUE_EN
        if (from_pend) pend_valid_nxt = 1'b0;
        if (accept && !(launch && !from_pend)) begin
            pend_valid_nxt = 1'b1;
            pend_dur_nxt   = bus.note_dur;
        end
`endif

        if (bus.abort) begin
            state_nxt   = IDLE;
            dur_lat_nxt = dur_lat;
            dur_cnt_nxt = '0;
            gap_cnt_nxt = '0;
            over_nxt    = 1'b0;
`ifdef PIEZO_DUR_QUEUE_EN
            pend_valid_nxt = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dur_lat <= '0;
            dur_cnt <= '0;
            gap_cnt <= '0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
`ifdef PIEZO_DUR_QUEUE_EN
            pend_valid <= 1'b0;
            pend_dur   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            dur_lat <= dur_lat_nxt;
            dur_cnt <= dur_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            busy_q  <= (state_nxt != IDLE);
            over_q  <= over_nxt;
`ifdef PIEZO_DUR_QUEUE_EN
            pend_valid <= pend_valid_nxt;
            pend_dur   <= pend_dur_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_piezo_dur_timer.sv
// Bench for piezo_dur_timer (default build): two instances, GAP_TICKS=2 and GAP_TICKS=0.
module tb_piezo_dur_timer;
    localparam int unsigned TD = 4;
    localparam int unsigned DW = 8;
    localparam int          GAPS [2] = '{2, 0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, pause = 1'b0;
    logic [DW-1:0] note_dur = '0;

    piezo_dur_timer_if #(.DUR_W(DW)) bus0 ();
    piezo_dur_timer_if #(.DUR_W(DW)) bus1 ();

    assign bus0.start = start;  assign bus0.abort = abort;
    assign bus0.pause = pause;  assign bus0.note_dur = note_dur;
    assign bus1.start = start;  assign bus1.abort = abort;
    assign bus1.pause = pause;  assign bus1.note_dur = note_dur;

    piezo_dur_timer #(.TICK_DIV(TD), .DUR_W(DW), .GAP_TICKS(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    piezo_dur_timer #(.TICK_DIV(TD), .DUR_W(DW), .GAP_TICKS(0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    logic d_busy [2], d_on [2], d_over [2], d_ready [2];
    assign d_busy[0] = bus0.busy;  assign d_on[0] = bus0.note_on;
    assign d_over[0] = bus0.note_over;  assign d_ready[0] = bus0.ready;
    assign d_busy[1] = bus1.busy;  assign d_on[1] = bus1.note_on;
    assign d_over[1] = bus1.note_over;  assign d_ready[1] = bus1.ready;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, inst, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a note consumes note_dur*TD unpaused cycles, the gap GAP*TD unpaused cycles.
    int   ph  [2] = '{0, 0};
    int   rem [2] = '{0, 0};
    logic m_over [2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0; rem[i] = 0; m_over[i] = 1'b0;
            end else begin
                logic nov;
                nov = 1'b0;
                if (ph[i] == 0) begin
                    if (start && !abort) begin
                        if (note_dur != 0) begin ph[i] = 1; rem[i] = int'(note_dur) * int'(TD); end
                        else if (GAPS[i] > 0) begin ph[i] = 2; rem[i] = GAPS[i] * int'(TD); end
                        else nov = 1'b1;
                    end
                end else if (abort) begin
                    ph[i] = 0;
                end else if (!pause) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        if (ph[i] == 1 && GAPS[i] > 0) begin ph[i] = 2; rem[i] = GAPS[i] * int'(TD); end
                        else begin ph[i] = 0; nov = 1'b1; end
                    end
                end
                m_over[i] = nov;
            end
        end
    end

    // Per-cycle compare plus observations relative to the last note start.
    int   on_cnt [2], on_first [2], on_last [2], ov_cnt [2], ov_first [2];
    logic busy_at_ov [2];
    int   last_t0 = -1;

    always @(negedge clk) begin
        if (t0 != last_t0) begin
            last_t0 = t0;
            for (int i = 0; i < 2; i++) begin
                on_cnt[i] = 0; on_first[i] = -1; on_last[i] = -1;
                ov_cnt[i] = 0; ov_first[i] = -1; busy_at_ov[i] = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("busy",      i, d_busy[i],  ph[i] != 0);
            chk("note_on",   i, d_on[i],    (ph[i] == 1) && !pause);
            chk("note_over", i, d_over[i],  m_over[i]);
            chk("ready",     i, d_ready[i], (ph[i] == 0) && !abort);
            if (d_on[i] === 1'b1) begin
                on_cnt[i]++;
                if (on_first[i] < 0) on_first[i] = cyc - t0;
                on_last[i] = cyc - t0;
            end
            if (d_over[i] === 1'b1) begin
                ov_cnt[i]++;
                if (ov_first[i] < 0) begin
                    ov_first[i]   = cyc - t0;
                    busy_at_ov[i] = d_busy[i];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [DW-1:0] d);
        start = 1'b1; note_dur = d; t0 = cyc;
        step();
        start = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_busy", 0, d_busy[0], 1'b0);
        chk("rst_ready", 0, d_ready[0], 1'b1);
        chk("rst_note_over", 0, d_over[0], 1'b0);
        rst = 1'b0;
        step();

        go(8'd3); repeat (25) step();
        chk_int("basic_on_first", on_first[0], 1);
        chk_int("basic_on_last", on_last[0], 12);
        chk_int("basic_over_at", ov_first[0], 21);
        chk_int("basic_over_cnt", ov_cnt[0], 1);
        chk("basic_busy_at_over", 0, busy_at_ov[0], 1'b0);

        go(8'd0); repeat (12) step();
        chk_int("zero_on_cnt", on_cnt[0], 0);
        chk_int("zero_over_at", ov_first[0], 9);
        chk_int("zero_nogap_over_at", ov_first[1], 1);

        go(8'd2); step(); step();
        pause = 1'b1; repeat (5) step(); pause = 1'b0;
        repeat (20) step();
        chk_int("pause_on_cnt", on_cnt[0], 8);
        chk_int("pause_over_at", ov_first[0], 22);

        go(8'd10); repeat (5) step();
        abort = 1'b1; step(); abort = 1'b0; step();
        chk_int("abort_on_last", on_last[0], 6);
        chk_int("abort_no_over", ov_cnt[0] + ov_cnt[1], 0);
        go(8'd3); repeat (25) step();
        chk_int("restart_on_first", on_first[0], 1);
        chk_int("restart_on_last", on_last[0], 12);
        chk_int("restart_over_at", ov_first[0], 21);

        go(8'd1); repeat (6) step();
        #2 rst = 1'b1;
        #1;
        chk("midgap_rst_busy", 0, d_busy[0], 1'b0);
        chk("midgap_rst_note_on", 0, d_on[0], 1'b0);
        chk("midgap_rst_note_over", 0, d_over[0], 1'b0);
        chk("midgap_rst_ready", 0, d_ready[0], 1'b1);
        step(); rst = 1'b0;
        repeat (15) step();
        chk_int("midgap_rst_no_over", ov_cnt[0], 0);

        go(8'd2); step();
        start = 1'b1; note_dur = 8'd5; step(); start = 1'b0;
        repeat (25) step();
        chk_int("ignore_over_cnt", ov_cnt[0], 1);
        chk_int("ignore_over_at", ov_first[0], 17);

        pause = 1'b1; go(8'd3); step(); pause = 1'b0;
        repeat (30) step();
        chk_int("idle_pause_on_first", on_first[0], 2);
        chk_int("idle_pause_over_at", ov_first[0], 22);

        go(8'd255); repeat (1035) step();
        chk_int("max_on_cnt", on_cnt[0], 1020);
        chk_int("max_over_at", ov_first[0], 1029);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
